// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the 5-stage miniLA core.
//               - Load-use detection in ID; stall FSM holds PC and IF/ID and
//                 inserts bubbles into ID/EX for LOAD_USE_STALL cycles.
//               - Taken branch / jump resolved in EX flushes IF/ID and ID/EX.
//               - Operand-forward selects computed in ID and registered so
//                 they reach EX together with the instruction.
// Optional    : HAZARD_PERF_EN - when defined, saturating perf counters for
//               load-use bubble cycles and redirect events are built; when
//               undefined, stall_cnt/flush_cnt are tied to zero.
// Parameters  : LOAD_USE_STALL - bubble cycles per load-use hazard (1..3)
//               CNT_W          - perf counter width
// Ports       : clk, rst_n (async, active-low)
//               id_rs1/id_rs2, id_rs1_used/id_rs2_used : ID source operands
//               ex_rd, ex_wb_ena, ex_is_load            : EX producer
//               mem_rd, mem_wb_ena                      : MEM producer
//               ex_redirect                             : EX branch/jump taken
//               pc_stall, if_id_stall                   : hold PC / IF/ID
//               if_id_flush, id_ex_flush                : load NOP / bubble
//               fwd_rs1_sel, fwd_rs2_sel                : 00 RF, 01 EX/MEM,
//                                                         10 MEM/WB
//               stall_cnt, flush_cnt                    : perf counters
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       mem_rd,
  input  logic             ex_wb_ena,
  input  logic             mem_wb_ena,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Remaining bubbles after the first one, which is issued from RUN.
  localparam logic [1:0] CNT_INIT = 2'(LOAD_USE_STALL - 1);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] fwd_rs1_sel_q, fwd_rs1_sel_d;
  logic [1:0] fwd_rs2_sel_q, fwd_rs2_sel_d;

  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  logic load_use;
  logic lu_bubble;   // this cycle's ID/EX bubble is caused by a load-use stall

  // --------------------------------------------------------------------------
  // Hazard detection. Register x0 is never a real dependency.
  // --------------------------------------------------------------------------
  always_comb begin
    ex_hit1  = id_rs1_used && (id_rs1 != 5'd0) && ex_wb_ena  && (ex_rd  == id_rs1);
    ex_hit2  = id_rs2_used && (id_rs2 != 5'd0) && ex_wb_ena  && (ex_rd  == id_rs2);
    mem_hit1 = id_rs1_used && (id_rs1 != 5'd0) && mem_wb_ena && (mem_rd == id_rs1);
    mem_hit2 = id_rs2_used && (id_rs2 != 5'd0) && mem_wb_ena && (mem_rd == id_rs2);
    // ex_hit already implies ex_rd != 0, so both operands hitting yields one stall.
    load_use = ex_is_load && (ex_hit1 || ex_hit2);
  end

  // --------------------------------------------------------------------------
  // Stall / flush FSM: next state and outputs.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    lu_bubble   = 1'b0;

    if (!rst_n) begin
      // Outputs stay quiet while reset is asserted, whatever the inputs do.
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end else if (ex_redirect) begin
      // The instruction held in ID is on the wrong path: drop it and any
      // remaining stall cycles, and let the PC take the redirect target.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = ST_RUN;
      cnt_d       = 2'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
            lu_bubble   = 1'b1;
            if (LOAD_USE_STALL > 1) begin
              state_d = ST_STALL;
              cnt_d   = CNT_INIT;
            end
          end
        end
        ST_STALL: begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_flush = 1'b1;
          lu_bubble   = 1'b1;
          cnt_d       = cnt_q - 2'd1;
          if (cnt_q <= 2'd1) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Forward selects. EX/MEM wins over MEM/WB because it is the younger
  // producer. A bubble entering ID/EX carries no operands, so it gets RF.
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_rs1_sel_d = SEL_RF;
    fwd_rs2_sel_d = SEL_RF;
    if (!id_ex_flush) begin
      if (ex_hit1) begin
        fwd_rs1_sel_d = SEL_EX;
      end else if (mem_hit1) begin
        fwd_rs1_sel_d = SEL_MEM;
      end
      if (ex_hit2) begin
        fwd_rs2_sel_d = SEL_EX;
      end else if (mem_hit2) begin
        fwd_rs2_sel_d = SEL_MEM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 2'd0;
      fwd_rs1_sel_q <= SEL_RF;
      fwd_rs2_sel_q <= SEL_RF;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fwd_rs1_sel_q <= fwd_rs1_sel_d;
      fwd_rs2_sel_q <= fwd_rs2_sel_d;
    end
  end

  assign fwd_rs1_sel = fwd_rs1_sel_q;
  assign fwd_rs2_sel = fwd_rs2_sel_q;

  // --------------------------------------------------------------------------
  // Performance counters (saturating, cleared only by reset).
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (lu_bubble && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    if (rst_n && ex_redirect && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Directed self-checking bench for hazard_ctrl. Two instances
//               share one stimulus: dut_a with LOAD_USE_STALL=1 and dut_b with
//               LOAD_USE_STALL=3. Control outputs are compared as the nibble
//               {pc_stall, if_id_stall, if_id_flush, id_ex_flush}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_used, id_rs2_used, ex_wb_ena, mem_wb_ena, ex_is_load, ex_redirect;

  logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush;
  logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush;
  logic [1:0]  a_fwd1, a_fwd2, b_fwd1, b_fwd2;
  logic [31:0] a_scnt, a_fcnt, b_scnt, b_fcnt;

  wire [3:0] a_ctl = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush};
  wire [3:0] b_ctl = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush};

  int n_vec = 0;
  int n_err = 0;

  hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wb_ena(ex_wb_ena), .mem_wb_ena(mem_wb_ena),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .fwd_rs1_sel(a_fwd1), .fwd_rs2_sel(a_fwd2),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .ex_wb_ena(ex_wb_ena), .mem_wb_ena(mem_wb_ena),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .fwd_rs1_sel(b_fwd1), .fwd_rs2_sel(b_fwd2),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Step to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one set of pipeline inputs and let the combinational outputs settle.
  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] erd, input logic ewb, input logic eld,
                       input logic [4:0] mrd, input logic mwb, input logic redir);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    ex_rd = erd; ex_wb_ena = ewb; ex_is_load = eld;
    mem_rd = mrd; mem_wb_ena = mwb; ex_redirect = redir;
    #1;
  endtask

  function automatic logic [31:0] pc(input int v);
    return PERF ? 32'(v) : 32'd0;
  endfunction

  task automatic chk_cnt(input string tag, input int sa, input int sb, input int f);
    chk({tag, " a_stall_cnt"}, a_scnt, pc(sa));
    chk({tag, " b_stall_cnt"}, b_scnt, pc(sb));
    chk({tag, " a_flush_cnt"}, a_fcnt, pc(f));
    chk({tag, " b_flush_cnt"}, b_fcnt, pc(f));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    #12;
    // ---------------- reset state
    chk("rst a_ctl", 32'(a_ctl), 32'h0);
    chk("rst b_ctl", 32'(b_ctl), 32'h0);
    chk("rst a_fwd", 32'({a_fwd1, a_fwd2}), 32'h0);
    chk_cnt("rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---------------- ld r5 in EX, add r6,r5,r1 in ID
    drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("lu a_ctl", 32'(a_ctl), 32'hD);
    chk("lu b_ctl", 32'(b_ctl), 32'hD);
    tick();
    // bubble in EX, load now in MEM; consumer still in ID
    drive(5'd5, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("lu bubble a_fwd1", 32'(a_fwd1), 32'h0);
    chk("lu2 a_ctl", 32'(a_ctl), 32'h0);
    chk("lu2 b_ctl", 32'(b_ctl), 32'hD);
    tick();
    chk("lu a_fwd1", 32'(a_fwd1), 32'h2);
    chk("lu a_fwd2", 32'(a_fwd2), 32'h0);
    chk("lu3 b_ctl", 32'(b_ctl), 32'hD);
    chk("lu3 b_fwd1", 32'(b_fwd1), 32'h0);
    tick();
    chk("lu4 b_ctl", 32'(b_ctl), 32'h0);
    chk("lu4 b_fwd1", 32'(b_fwd1), 32'h0);
    chk_cnt("lu", 1, 3, 0);
    tick();
    chk("lu5 b_fwd1", 32'(b_fwd1), 32'h2);

    // ---------------- ALU r7 in EX and MEM, ID reads rs2=7: EX priority
    drive(5'd3, 1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0);
    chk("prio a_ctl", 32'(a_ctl), 32'h0);
    chk("prio b_ctl", 32'(b_ctl), 32'h0);
    tick();
    chk("prio a_fwd", 32'({a_fwd1, a_fwd2}), 32'h1);
    chk("prio b_fwd", 32'({b_fwd1, b_fwd2}), 32'h1);

    // ---------------- MEM-only producer on rs1; rs2 matches but unused
    drive(5'd4, 1'b1, 5'd4, 1'b0, 5'd9, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0);
    tick();
    chk("mem a_fwd", 32'({a_fwd1, a_fwd2}), 32'h8);

    // ---------------- both operands on the same EX producer
    drive(5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("both a_fwd", 32'({a_fwd1, a_fwd2}), 32'h5);

    // ---------------- x0: load to r0 never stalls or forwards
    drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0);
    chk("x0 a_ctl", 32'(a_ctl), 32'h0);
    chk("x0 b_ctl", 32'(b_ctl), 32'h0);
    tick();
    chk("x0 a_fwd", 32'({a_fwd1, a_fwd2}), 32'h0);

    // ---------------- redirect in cycle 2 of 3-cycle stall
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    chk("rd1 b_ctl", 32'(b_ctl), 32'hD);
    tick();
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1);
    chk("redir a_ctl", 32'(a_ctl), 32'h3);
    chk("redir b_ctl", 32'(b_ctl), 32'h3);
    tick();
    chk("redir b_fwd1", 32'(b_fwd1), 32'h0);
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("post redir b_ctl", 32'(b_ctl), 32'h0);
    chk_cnt("redir", 2, 4, 1);

    // ---------------- redirect overrides a load-use in RUN
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1);
    chk("ovr a_ctl", 32'(a_ctl), 32'h3);
    chk("ovr b_ctl", 32'(b_ctl), 32'h3);
    tick();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("post ovr b_ctl", 32'(b_ctl), 32'h0);
    chk_cnt("ovr", 2, 4, 2);

    // ---------------- asynchronous reset mid-STALL
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0);
    tick();
    drive(5'd8, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    chk("pre rst b_ctl", 32'(b_ctl), 32'hD);
    chk("pre rst a_fwd1", 32'(a_fwd1), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid rst a_ctl", 32'(a_ctl), 32'h0);
    chk("mid rst b_ctl", 32'(b_ctl), 32'h0);
    chk("mid rst a_fwd1", 32'(a_fwd1), 32'h0);
    chk("mid rst a_stall_cnt", a_scnt, 32'h0);
    chk("mid rst b_stall_cnt", b_scnt, 32'h0);
    chk("mid rst b_flush_cnt", b_fcnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    chk("post rst b_ctl", 32'(b_ctl), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
